csr_xfer_engine: RTL and testbench
==================================

Name: csr_xfer_engine

Overview:
- mem_clk-domain engine in MAIN_CNTRL that consumes the single-cycle csr_cmd_xfer_valid_final and csr_rd_xfer_valid_final pulses produced by the CSR instruction handler.
- Captures the CSR-programmed instruction fields and drives one request/ack transaction to the memory sequencer.
- For reads, packs the returned bytes into a 32-bit status word.
- Returns csr_cmd_xfer_success / csr_rd_xfer_success pulses, which close the special-instruction stall upstream.

Parameters:
- TIMEOUT_W, 16, width of the transaction timeout counter and of csr_timeout_val.
- RD_BYTES_MAX, 4, maximum read bytes packed into csr_rd_data (fixed 4 for a 32-bit word).

Ports:
- mem_clk  in  1  memory-domain clock.
- mem_rst  in  1  reset, synchronous, active-high.
- csr_cmd_xfer_valid_final  in  1  pulse: start a command-only transfer.
- csr_rd_xfer_valid_final  in  1  pulse: start a command-plus-read transfer.
- csr_cmd_opcode  in  8  instruction opcode, quasi-static.
- csr_cmd_addr  in  32  address, quasi-static.
- csr_cmd_addr_en  in  1  address phase present.
- csr_dummy_cyc  in  5  dummy cycles.
- csr_rd_byte_cnt  in  2  read bytes minus 1 (0..3 gives 1..4).
- csr_timeout_val  in  TIMEOUT_W  timeout in mem_clk cycles; 0 disables the timeout.
- seq_req  out  1  request to memory sequencer.
- seq_opcode  out  8  captured opcode.
- seq_addr  out  32  captured address.
- seq_addr_en  out  1  captured address enable.
- seq_dummy  out  5  captured dummy cycles.
- seq_rd_en  out  1  transfer has a read phase.
- seq_rd_bytes  out  3  read byte count, 1..4.
- seq_abort  out  1  pulse: abandon the current transfer.
- seq_ack  in  1  sequencer accepted the request.
- seq_rdata  in  8  read byte.
- seq_rdata_valid  in  1  seq_rdata qualifier.
- seq_done  in  1  pulse: transfer complete on the bus.
- csr_rd_data  out  32  packed read data.
- csr_cmd_xfer_success  out  1  pulse.
- csr_rd_xfer_success  out  1  pulse.
- csr_xfer_err  out  1  pulse: timeout or short read.
- csr_xfer_drop  out  1  sticky: a start pulse arrived while busy.
- csr_drop_clr  in  1  clears csr_xfer_drop.
- csr_xfer_busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (mem_rst sampled high at a mem_clk edge):
  - All outputs are 0 and state goes to IDLE.
  - csr_rd_data and the captured fields are 0.
  - Reset mid-transfer abandons the transfer with no success or err pulse.
- States: IDLE, REQ, XFER, DONE.
- IDLE:
  - On either start pulse: capture all csr_* fields into seq_* registers, clear csr_rd_data and the byte index, load the timeout counter, and go to REQ next cycle.
  - Both pulses in the same cycle: treated as a read, with no drop flagged.
  - seq_rd_bytes = csr_rd_byte_cnt + 1, zero-extended to 3 bits.
- REQ:
  - seq_req held high until seq_ack is sampled high.
  - seq_ack sampled high: go to XFER and drop seq_req in the same edge. There is no combinational path from seq_ack to seq_req.
- XFER, read:
  - Each seq_rdata_valid writes byte[idx] of csr_rd_data, little-endian (byte 0 in bits 7:0), and increments idx.
  - Bytes beyond seq_rd_bytes are ignored.
  - A seq_rdata_valid coincident with seq_done is stored before completion is evaluated.
- XFER, completion on seq_done:
  - Command transfer: go to DONE.
  - Read with idx == seq_rd_bytes: go to DONE.
  - Read with fewer bytes: pulse csr_xfer_err, go to IDLE, no success. Partial data is retained.
- DONE:
  - One cycle; pulse csr_rd_xfer_success or csr_cmd_xfer_success according to the captured type, then go to IDLE.
  - Latency from start pulse to seq_req is 1 cycle.
  - Latency from seq_done to the success pulse is 1 cycle.
- Timeout:
  - Counter runs in REQ and XFER.
  - When it reaches csr_timeout_val (nonzero): pulse seq_abort and csr_xfer_err, deassert seq_req, go to IDLE.
  - If seq_done and the timeout hit in the same cycle, seq_done wins.
- Start pulse while not IDLE: ignored and csr_xfer_drop is set. Set takes priority over a same-cycle csr_drop_clr.
- seq_ack, seq_done and seq_rdata_valid are ignored in states where they are not expected.

Optional Feature:
- Macro CSR_XFER_TIMEOUT_EN.
- Defined: the timeout counter and seq_abort behave as described above.
- Undefined:
  - No counter is built; seq_abort is tied 0.
  - csr_timeout_val is present but ignored.
  - csr_xfer_err is raised only for a short read.
  - The engine waits indefinitely in REQ and XFER.

Decomposition:
- Package csr_xfer_pkg holds:
  - state enumeration (IDLE, REQ, XFER, DONE) as a 2-bit encoding;
  - xfer type constants (XFER_CMD, XFER_RD);
  - byte-index width (3) and RD_WORD_W = 32.
- One sub-module, csr_rd_byte_packer:
  - holds the byte index, csr_rd_data register and the capped write enable;
  - has clear, byte-valid, byte-data and max-count inputs;
  - provides a count-reached output.

Test Plan:
- Command transfer, no read:
  - Stimulus: csr_cmd_xfer_valid_final pulse with opcode 0x06, addr_en 0; seq_ack 2 cycles after seq_req; seq_done 5 cycles later.
  - Response: seq_req high exactly 1 cycle after the start pulse, seq_rd_en = 0, csr_cmd_xfer_success a single pulse 1 cycle after seq_done, busy low afterward.
- Full 4-byte read:
  - Stimulus: rd pulse with byte_cnt = 3; bytes 0x11, 0x22, 0x33, 0x44, then seq_done.
  - Response: csr_rd_data = 0x44332211, csr_rd_xfer_success pulses once.
- Short read:
  - Stimulus: byte_cnt = 1; one byte 0xA5, then seq_done.
  - Response: csr_xfer_err pulse, no success, csr_rd_data = 0x000000A5.
- Timeout (macro defined):
  - Stimulus: csr_timeout_val = 10; seq_ack never asserted.
  - Response: seq_abort and csr_xfer_err pulse 10 cycles after REQ entry, seq_req drops, state returns to IDLE.
- Start while busy, then clear:
  - Stimulus: rd pulse during XFER, then csr_drop_clr.
  - Response: csr_xfer_drop = 1 and the current transfer completes unaffected; csr_drop_clr returns csr_xfer_drop to 0.
- Reset mid-transfer:
  - Stimulus: mem_rst asserted in XFER.
  - Response: all outputs 0 the next cycle, and no success or err pulse.

Source files
------------

// File: rtl/csr_xfer_pkg.sv
// Shared types and constants for the CSR transfer engine.
package csr_xfer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } xfer_state_t;

    localparam logic XFER_CMD = 1'b0;
    localparam logic XFER_RD  = 1'b1;

    localparam int IDX_W     = 3;
    localparam int RD_WORD_W = 32;

endpackage

// File: rtl/csr_rd_byte_packer.sv
// Packs returned read bytes little-endian into a word.
// Writes beyond max_cnt are dropped.
// cnt_reached already accounts for a byte arriving this cycle.
module csr_rd_byte_packer
    import csr_xfer_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  byte_vld,
    input  logic [7:0]            byte_data,
    input  logic [IDX_W-1:0]      max_cnt,
    output logic [NBYTES*8-1:0]   rd_data,
    output logic                  cnt_reached
);

    logic [IDX_W-1:0] idx;
    logic             wr_en;

    assign wr_en       = byte_vld && (idx < max_cnt);
    assign cnt_reached = ((idx + IDX_W'(wr_en)) == max_cnt);

    // Byte index and data word; cleared at the start of each transfer.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            idx     <= '0;
            rd_data <= '0;
        end else if (wr_en) begin
            rd_data[{idx[1:0], 3'b000} +: 8] <= byte_data;
            idx                              <= idx + 1'b1;
        end
    end

endmodule

// File: rtl/csr_xfer_engine.sv
// CSR special-instruction transfer engine (mem_clk domain).
// Runs one request/ack transaction to the memory sequencer per start pulse.
// CSR_XFER_TIMEOUT_EN: when defined, builds the REQ/XFER timeout counter
// and drives seq_abort; when undefined, the engine waits indefinitely.
module csr_xfer_engine
    import csr_xfer_pkg::*;
#(
    parameter int TIMEOUT_W    = 16,
    parameter int RD_BYTES_MAX = 4
) (
    input  logic                 mem_clk,
    input  logic                 mem_rst,
    input  logic                 csr_cmd_xfer_valid_final,
    input  logic                 csr_rd_xfer_valid_final,
    input  logic [7:0]           csr_cmd_opcode,
    input  logic [31:0]          csr_cmd_addr,
    input  logic                 csr_cmd_addr_en,
    input  logic [4:0]           csr_dummy_cyc,
    input  logic [1:0]           csr_rd_byte_cnt,
    input  logic [TIMEOUT_W-1:0] csr_timeout_val,
    output logic                 seq_req,
    output logic [7:0]           seq_opcode,
    output logic [31:0]          seq_addr,
    output logic                 seq_addr_en,
    output logic [4:0]           seq_dummy,
    output logic                 seq_rd_en,
    output logic [2:0]           seq_rd_bytes,
    output logic                 seq_abort,
    input  logic                 seq_ack,
    input  logic [7:0]           seq_rdata,
    input  logic                 seq_rdata_valid,
    input  logic                 seq_done,
    output logic [RD_WORD_W-1:0] csr_rd_data,
    output logic                 csr_cmd_xfer_success,
    output logic                 csr_rd_xfer_success,
    output logic                 csr_xfer_err,
    output logic                 csr_xfer_drop,
    input  logic                 csr_drop_clr,
    output logic                 csr_xfer_busy
);

    xfer_state_t state;
    logic        start;
    logic        cnt_reached;
    logic        tmo_hit;

    assign start         = csr_cmd_xfer_valid_final || csr_rd_xfer_valid_final;
    assign csr_xfer_busy = (state != IDLE);

`ifdef CSR_XFER_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] tmo_cnt;
    logic [TIMEOUT_W-1:0] tmo_nxt;

    assign tmo_nxt = tmo_cnt + 1'b1;
    assign tmo_hit = (csr_timeout_val != '0) && (tmo_nxt == csr_timeout_val);

    // Cycles spent in REQ+XFER; idle keeps it at zero so each transfer starts fresh.
    always_ff @(posedge mem_clk) begin
        if (mem_rst || state == IDLE)
            tmo_cnt <= '0;
        else if (state == REQ || state == XFER)
            tmo_cnt <= tmo_nxt;
    end
`else
    logic tmo_val_unused;

    assign tmo_hit        = 1'b0;
    assign tmo_val_unused = ^csr_timeout_val;
`endif

    csr_rd_byte_packer #(.NBYTES(RD_BYTES_MAX)) u_packer (
        .clk         (mem_clk),
        .rst         (mem_rst),
        .clr         (state == IDLE && start),
        .byte_vld    (state == XFER && seq_rd_en == XFER_RD && seq_rdata_valid),
        .byte_data   (seq_rdata),
        .max_cnt     (seq_rd_bytes),
        .rd_data     (csr_rd_data),
        .cnt_reached (cnt_reached)
    );

    // Transfer FSM with registered request, status pulses and sticky drop flag.
    always_ff @(posedge mem_clk) begin
        if (mem_rst) begin
            state                <= IDLE;
            seq_req              <= 1'b0;
            seq_opcode           <= '0;
            seq_addr             <= '0;
            seq_addr_en          <= 1'b0;
            seq_dummy            <= '0;
            seq_rd_en            <= XFER_CMD;
            seq_rd_bytes         <= '0;
            seq_abort            <= 1'b0;
            csr_cmd_xfer_success <= 1'b0;
            csr_rd_xfer_success  <= 1'b0;
            csr_xfer_err         <= 1'b0;
            csr_xfer_drop        <= 1'b0;
        end else begin
            seq_abort            <= 1'b0;
            csr_cmd_xfer_success <= 1'b0;
            csr_rd_xfer_success  <= 1'b0;
            csr_xfer_err         <= 1'b0;

            if (start && state != IDLE)
                csr_xfer_drop <= 1'b1;
            else if (csr_drop_clr)
                csr_xfer_drop <= 1'b0;

            case (state)
                IDLE: if (start) begin
                    seq_opcode   <= csr_cmd_opcode;
                    seq_addr     <= csr_cmd_addr;
                    seq_addr_en  <= csr_cmd_addr_en;
                    seq_dummy    <= csr_dummy_cyc;
                    seq_rd_en    <= csr_rd_xfer_valid_final ? XFER_RD : XFER_CMD;
                    seq_rd_bytes <= {1'b0, csr_rd_byte_cnt} + 3'd1;
                    seq_req      <= 1'b1;
                    state        <= REQ;
                end
                REQ: if (seq_ack) begin
                    seq_req <= 1'b0;
                    state   <= XFER;
                end else if (tmo_hit) begin
                    seq_req      <= 1'b0;
                    seq_abort    <= 1'b1;
                    csr_xfer_err <= 1'b1;
                    state        <= IDLE;
                end
                XFER: if (seq_done) begin
                    // Success pulse is raised on entry to DONE so it lands
                    // one cycle after seq_done.
                    if (seq_rd_en == XFER_CMD) begin
                        csr_cmd_xfer_success <= 1'b1;
                        state                <= DONE;
                    end else if (cnt_reached) begin
                        csr_rd_xfer_success <= 1'b1;
                        state               <= DONE;
                    end else begin
                        csr_xfer_err <= 1'b1;
                        state        <= IDLE;
                    end
                end else if (tmo_hit) begin
                    seq_abort    <= 1'b1;
                    csr_xfer_err <= 1'b1;
                    state        <= IDLE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_xfer_engine.sv
// Directed bench for csr_xfer_engine; timeout section follows CSR_XFER_TIMEOUT_EN.
module tb_csr_xfer_engine;

    logic        mem_clk = 1'b0;
    logic        mem_rst = 1'b1;
    logic        cmd_v = 1'b0, rd_v = 1'b0;
    logic [7:0]  opcode = '0;
    logic [31:0] addr = '0;
    logic        addr_en = 1'b0;
    logic [4:0]  dummy = '0;
    logic [1:0]  byte_cnt = '0;
    logic [15:0] tmo_val = '0;
    logic        seq_req, seq_addr_en, seq_rd_en, seq_abort;
    logic [7:0]  seq_opcode;
    logic [31:0] seq_addr;
    logic [4:0]  seq_dummy;
    logic [2:0]  seq_rd_bytes;
    logic        seq_ack = 1'b0;
    logic [7:0]  seq_rdata = '0;
    logic        seq_rdata_valid = 1'b0;
    logic        seq_done = 1'b0;
    logic [31:0] rd_data;
    logic        cmd_ok, rd_ok, err, drop, busy;
    logic        drop_clr = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 mem_clk = ~mem_clk;

    csr_xfer_engine dut (
        .mem_clk(mem_clk), .mem_rst(mem_rst),
        .csr_cmd_xfer_valid_final(cmd_v), .csr_rd_xfer_valid_final(rd_v),
        .csr_cmd_opcode(opcode), .csr_cmd_addr(addr), .csr_cmd_addr_en(addr_en),
        .csr_dummy_cyc(dummy), .csr_rd_byte_cnt(byte_cnt), .csr_timeout_val(tmo_val),
        .seq_req(seq_req), .seq_opcode(seq_opcode), .seq_addr(seq_addr),
        .seq_addr_en(seq_addr_en), .seq_dummy(seq_dummy), .seq_rd_en(seq_rd_en),
        .seq_rd_bytes(seq_rd_bytes), .seq_abort(seq_abort), .seq_ack(seq_ack),
        .seq_rdata(seq_rdata), .seq_rdata_valid(seq_rdata_valid), .seq_done(seq_done),
        .csr_rd_data(rd_data), .csr_cmd_xfer_success(cmd_ok), .csr_rd_xfer_success(rd_ok),
        .csr_xfer_err(err), .csr_xfer_drop(drop), .csr_drop_clr(drop_clr),
        .csr_xfer_busy(busy)
    );

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge mem_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        seq_rdata_valid = 1'b1;
        seq_rdata       = b;
        tick();
        seq_rdata_valid = 1'b0;
    endtask

    initial begin
        // Reset
        tick(); tick();
        chk("rst_req", seq_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", rd_data, 0);
        chk("rst_flags", {seq_abort, cmd_ok, rd_ok, err, drop, seq_rd_en}, 0);
        chk("rst_fields", {seq_opcode, seq_rd_bytes, seq_dummy}, 0);
        mem_rst = 1'b0;
        tick();

        // Command transfer
        opcode = 8'h06; addr = 32'h0000_1234; addr_en = 1'b0; dummy = 5'd2; byte_cnt = 2'd0;
        cmd_v = 1'b1; tick(); cmd_v = 1'b0;
        chk("cmd_req_lat1", seq_req, 1);
        chk("cmd_rd_en", seq_rd_en, 0);
        chk("cmd_fields", {seq_opcode, seq_addr_en, seq_dummy}, {8'h06, 1'b0, 5'd2});
        chk("cmd_addr", seq_addr, 32'h0000_1234);
        tick();
        chk("cmd_req_hold", seq_req, 1);
        seq_ack = 1'b1; tick(); seq_ack = 1'b0;
        chk("cmd_req_drop", seq_req, 0);
        chk("cmd_xfer_busy", busy, 1);
        tick(); tick(); tick(); tick();
        chk("cmd_no_early_ok", cmd_ok, 0);
        seq_done = 1'b1; tick(); seq_done = 1'b0;
        chk("cmd_ok_pulse", {cmd_ok, rd_ok, err}, 3'b100);
        tick();
        chk("cmd_ok_single", cmd_ok, 0);
        chk("cmd_busy_low", busy, 0);

        // Full 4-byte read, plus an extra byte that must be ignored
        opcode = 8'h9F; byte_cnt = 2'd3;
        rd_v = 1'b1; tick(); rd_v = 1'b0;
        chk("rd4_rd_en", seq_rd_en, 1);
        chk("rd4_bytes", seq_rd_bytes, 4);
        seq_ack = 1'b1; tick(); seq_ack = 1'b0;
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h55);
        chk("rd4_extra_ignored", rd_data, 32'h4433_2211);
        seq_done = 1'b1; tick(); seq_done = 1'b0;
        chk("rd4_ok", {cmd_ok, rd_ok, err}, 3'b010);
        chk("rd4_data", rd_data, 32'h4433_2211);
        tick();
        chk("rd4_ok_single", rd_ok, 0);

        // Short read: 2 expected, 1 delivered; data cleared on start
        byte_cnt = 2'd1;
        rd_v = 1'b1; tick(); rd_v = 1'b0;
        chk("short_cleared", rd_data, 0);
        seq_ack = 1'b1; tick(); seq_ack = 1'b0;
        send_byte(8'hA5);
        seq_done = 1'b1; tick(); seq_done = 1'b0;
        chk("short_err", {cmd_ok, rd_ok, err}, 3'b001);
        chk("short_idle", busy, 0);
        chk("short_data", rd_data, 32'h0000_00A5);
        tick();
        chk("short_err_single", err, 0);

        // Single byte arriving together with seq_done completes the read
        byte_cnt = 2'd0;
        rd_v = 1'b1; tick(); rd_v = 1'b0;
        seq_ack = 1'b1; tick(); seq_ack = 1'b0;
        seq_rdata_valid = 1'b1; seq_rdata = 8'h5A; seq_done = 1'b1;
        tick();
        seq_rdata_valid = 1'b0; seq_done = 1'b0;
        chk("coinc_ok", {cmd_ok, rd_ok, err}, 3'b010);
        chk("coinc_data", rd_data, 32'h0000_005A);
        tick();

        // Timeout with seq_ack never asserted
        tmo_val = 16'd10;
        cmd_v = 1'b1; tick(); cmd_v = 1'b0;
        for (int i = 0; i < 9; i++) tick();
`ifdef CSR_XFER_TIMEOUT_EN
        chk("tmo_not_yet", {seq_abort, err, seq_req}, 3'b001);
        tick();
        chk("tmo_fire", {seq_abort, err, seq_req}, 3'b110);
        chk("tmo_idle", busy, 0);
        tick();
        chk("tmo_pulse_single", {seq_abort, err}, 2'b00);
`else
        for (int i = 0; i < 11; i++) tick();
        chk("notmo_wait", {seq_abort, err, seq_req, busy}, 4'b0011);
        seq_ack = 1'b1; tick(); seq_ack = 1'b0;
        seq_done = 1'b1; tick(); seq_done = 1'b0;
        chk("notmo_ok", cmd_ok, 1);
        tick();
`endif
        tmo_val = 16'd0;

        // Start while busy (with same-cycle clear), then clear
        opcode = 8'h03; byte_cnt = 2'd1;
        rd_v = 1'b1; tick(); rd_v = 1'b0;
        seq_ack = 1'b1; tick(); seq_ack = 1'b0;
        opcode = 8'h99; rd_v = 1'b1; drop_clr = 1'b1; tick(); rd_v = 1'b0; drop_clr = 1'b0;
        chk("drop_set", drop, 1);
        chk("drop_opcode_kept", seq_opcode, 8'h03);
        send_byte(8'h01); send_byte(8'h02);
        seq_done = 1'b1; tick(); seq_done = 1'b0;
        chk("drop_xfer_ok", {rd_ok, err}, 2'b10);
        chk("drop_xfer_data", rd_data, 32'h0000_0201);
        tick();
        chk("drop_sticky", drop, 1);
        drop_clr = 1'b1; tick(); drop_clr = 1'b0;
        chk("drop_cleared", drop, 0);

        // Both pulses together read as a read, no drop; then reset mid-transfer
        opcode = 8'h0B; byte_cnt = 2'd2;
        cmd_v = 1'b1; rd_v = 1'b1; tick(); cmd_v = 1'b0; rd_v = 1'b0;
        chk("both_is_rd", {seq_rd_en, drop, seq_rd_bytes}, {1'b1, 1'b0, 3'd3});
        seq_ack = 1'b1; tick(); seq_ack = 1'b0;
        send_byte(8'h77);
        mem_rst = 1'b1; tick();
        chk("mrst_flags", {seq_req, busy, cmd_ok, rd_ok, err, seq_abort, drop, seq_rd_en}, 0);
        chk("mrst_data", rd_data, 0);
        chk("mrst_fields", {seq_opcode, seq_rd_bytes}, 0);
        mem_rst = 1'b0;
        seq_done = 1'b1; tick(); seq_done = 1'b0;
        chk("mrst_no_pulse", {cmd_ok, rd_ok, err, busy}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
